// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// This covers opcode constants, the FSM state encoding and the flush NOP word.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection against the instruction held in decode.
// This block is purely combinational.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [31:0] id_instr,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   output logic        hazard
);

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        uses_rs;
   logic        uses_rt;
   logic        unused_low;

   assign op         = id_instr[31:26];
   assign rs         = id_instr[25:21];
   assign rt         = id_instr[20:16];
   assign unused_low = ^id_instr[15:0];

   // lw only reads rs; rt is its destination, so a match on rt is not a hazard.
   assign uses_rs = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
   assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);

   assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                   ((uses_rs && (rs == ex_rt)) || (uses_rt && (rt == ex_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: it owns IF/ID, stalls on load-use and flushes on taken beq.
// It also keeps saturating event counters for stalls and flushes.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16,
   parameter logic [31:0] NOP   = pipe_pkg::NOP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      if_instr,
   input  logic [31:0]      if_pc_plus4,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch,
   input  logic             mem_zero,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc_plus4,
   output logic             pc_write,
   output logic             pc_src,
   output logic             id_ex_bubble,
   output logic             flush_ex,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipe_pkg::*;

   state_e            state_q, state_d;
   logic [31:0]       instr_q, pc_q;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic              hazard, taken, stall;
   logic              load_ifid, squash_ifid;

   hazard_detect u_hazard_detect (
      .id_instr    (instr_q),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .hazard      (hazard)
   );

   assign taken = mem_branch && mem_zero;
   // Decode holds a NOP right after a flush, so hazards are masked there.
   assign stall = hazard && (state_q != ST_FLUSH) && !taken;

   always_comb begin
      pc_write     = 1'b1;
      pc_src       = 1'b0;
      id_ex_bubble = 1'b0;
      flush_ex     = 1'b0;
      load_ifid    = 1'b1;
      squash_ifid  = 1'b0;
      state_d      = ST_RUN;
      if (taken) begin
         pc_src       = 1'b1;
         id_ex_bubble = 1'b1;
         flush_ex     = 1'b1;
         squash_ifid  = 1'b1;
         state_d      = ST_FLUSH;
      end else if (stall) begin
         pc_write     = 1'b0;
         id_ex_bubble = 1'b1;
         load_ifid    = 1'b0;
         state_d      = ST_STALL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         instr_q     <= NOP;
         pc_q        <= 32'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (squash_ifid) begin
            instr_q <= NOP;
            pc_q    <= 32'd0;
         end else if (load_ifid) begin
            instr_q <= if_instr;
            pc_q    <= if_pc_plus4;
         end
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (taken && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign id_instr    = instr_q;
   assign id_pc_plus4 = pc_q;
   assign state_o     = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed expectations per cycle.
// A negedge monitor pops the queue and compares each field.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 2;

   localparam logic [31:0] ADD = 32'h0044_1820; // add $3,$2,$4
   localparam logic [31:0] LW  = 32'h8CC5_0000; // lw  $5,0($6)
   localparam logic [31:0] F1  = 32'h2001_0001; // addi, reads no checked field
   localparam logic [31:0] F2  = 32'h2002_0002;

   typedef struct {
      logic        pw, src, bub, fl;
      logic [1:0]  st;
      logic [31:0] id, pc;
      logic [1:0]  sc, fc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      if_instr, if_pc_plus4;
   logic             ex_mem_read, mem_branch, mem_zero;
   logic [4:0]       ex_rt;
   logic [31:0]      id_instr, id_pc_plus4;
   logic             pc_write, pc_src, id_ex_bubble, flush_ex;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   popped = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .if_instr     (if_instr),
      .if_pc_plus4  (if_pc_plus4),
      .ex_mem_read  (ex_mem_read),
      .ex_rt        (ex_rt),
      .mem_branch   (mem_branch),
      .mem_zero     (mem_zero),
      .id_instr     (id_instr),
      .id_pc_plus4  (id_pc_plus4),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .id_ex_bubble (id_ex_bubble),
      .flush_ex     (flush_ex),
      .state_o      (state_o),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   task automatic check(input string name, input int vec, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h, expected %0h", name, vec, act, exp);
      end
   endtask

   // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("pc_write",     popped, {31'd0, pc_write},     {31'd0, e.pw});
         check("pc_src",       popped, {31'd0, pc_src},       {31'd0, e.src});
         check("id_ex_bubble", popped, {31'd0, id_ex_bubble}, {31'd0, e.bub});
         check("flush_ex",     popped, {31'd0, flush_ex},     {31'd0, e.fl});
         check("state_o",      popped, {30'd0, state_o},      {30'd0, e.st});
         check("id_instr",     popped, id_instr,              e.id);
         check("id_pc_plus4",  popped, id_pc_plus4,           e.pc);
         check("stall_cnt",    popped, {30'd0, stall_cnt},    {30'd0, e.sc});
         check("flush_cnt",    popped, {30'd0, flush_cnt},    {30'd0, e.fc});
         popped++;
      end
   end

   // Drive one cycle of inputs, queue the expected in-cycle response, advance to next cycle.
   task automatic vec(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                      input logic mr, input logic [4:0] rt, input logic mb, input logic mz,
                      input logic [3:0] ctl, input logic [1:0] st, input logic [31:0] e_id,
                      input logic [31:0] e_pc, input logic [1:0] sc, input logic [1:0] fc);
      exp_t e;
      reset       = rst;
      if_instr    = ins;
      if_pc_plus4 = pc;
      ex_mem_read = mr;
      ex_rt       = rt;
      mem_branch  = mb;
      mem_zero    = mz;
      e.pw  = ctl[3];
      e.src = ctl[2];
      e.bub = ctl[1];
      e.fl  = ctl[0];
      e.st  = st;
      e.id  = e_id;
      e.pc  = e_pc;
      e.sc  = sc;
      e.fc  = fc;
      exp_q.push_back(e);
      pushed++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      if_instr    = F1;
      if_pc_plus4 = 32'd100;
      ex_mem_read = 1'b0;
      ex_rt       = 5'd0;
      mem_branch  = 1'b0;
      mem_zero    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      //  rst ins  pc   mr  rt     mb  mz  pw/src/bub/fl st   id   pc    sc    fc
      vec(0, ADD, 4,  0, 5'd0, 0, 0, 4'b1000, 2'd0, 0,   0,  2'd0, 2'd0); // reset state
      vec(0, F1,  8,  1, 5'd2, 0, 0, 4'b0010, 2'd0, ADD, 4,  2'd0, 2'd0); // load-use on rs
      vec(0, ADD, 8,  0, 5'd0, 0, 0, 4'b1000, 2'd1, ADD, 4,  2'd1, 2'd0); // one bubble, held
      vec(0, LW,  12, 1, 5'd0, 0, 0, 4'b1000, 2'd0, ADD, 8,  2'd1, 2'd0); // ex_rt=0 no stall
      vec(0, F1,  16, 1, 5'd5, 0, 0, 4'b1000, 2'd0, LW,  12, 2'd1, 2'd0); // lw rt no stall
      vec(0, F2,  20, 0, 5'd0, 1, 1, 4'b1111, 2'd0, F1,  16, 2'd1, 2'd0); // taken branch
      vec(0, F2,  24, 0, 5'd0, 0, 0, 4'b1000, 2'd2, 0,   0,  2'd1, 2'd1); // FLUSH, NOP in ID
      vec(0, ADD, 28, 0, 5'd0, 0, 0, 4'b1000, 2'd0, F2,  24, 2'd1, 2'd1);
      vec(0, F1,  32, 1, 5'd4, 1, 1, 4'b1111, 2'd0, ADD, 28, 2'd1, 2'd1); // hazard + taken
      vec(0, F1,  36, 0, 5'd0, 1, 1, 4'b1111, 2'd2, 0,   0,  2'd1, 2'd2); // taken in FLUSH
      vec(0, ADD, 40, 0, 5'd0, 1, 0, 4'b1000, 2'd2, 0,   0,  2'd1, 2'd3); // beq not taken
      vec(0, F1,  44, 1, 5'd2, 0, 0, 4'b0010, 2'd0, ADD, 40, 2'd1, 2'd3); // stall 2
      vec(0, F1,  44, 1, 5'd4, 0, 0, 4'b0010, 2'd1, ADD, 40, 2'd2, 2'd3); // back-to-back, rt
      vec(0, F1,  44, 1, 5'd2, 0, 0, 4'b0010, 2'd1, ADD, 40, 2'd3, 2'd3); // stall 4
      vec(0, F1,  44, 1, 5'd2, 0, 0, 4'b0010, 2'd1, ADD, 40, 2'd3, 2'd3); // stall 5 saturates
      vec(0, F1,  44, 0, 5'd0, 1, 1, 4'b1111, 2'd1, ADD, 40, 2'd3, 2'd3); // taken from STALL
      vec(0, ADD, 44, 0, 5'd0, 0, 0, 4'b1000, 2'd2, 0,   0,  2'd3, 2'd3); // flush_cnt saturated
      vec(0, F1,  48, 1, 5'd2, 0, 0, 4'b0010, 2'd0, ADD, 44, 2'd3, 2'd3); // enter STALL
      vec(1, F1,  48, 1, 5'd2, 1, 1, 4'b1111, 2'd1, ADD, 44, 2'd3, 2'd3); // reset mid-stall
      vec(0, F1,  48, 0, 5'd0, 0, 0, 4'b1000, 2'd0, 0,   0,  2'd0, 2'd0); // after reset
      vec(0, F2,  52, 0, 5'd0, 0, 0, 4'b1000, 2'd0, F1,  48, 2'd0, 2'd0);
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
      check("drained", 0, popped, pushed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It owns the IF/ID pipeline register that feeds the instruction-decode stage, and it detects load-use hazards against the instruction currently in ID. It also resolves taken-branch flushes signalled from the MEM stage and drives PC-write, PC-select, bubble and flush controls to the other stages. Stall and flush events are counted for performance debug.

Parameters:
CNT_W, 16, width of the stall and flush event counters (saturating)
NOP, 32'h0000_0000, instruction word loaded into IF/ID on flush/reset

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_instr  input  32  instruction fetched this cycle
if_pc_plus4  input  32  PC+4 of fetched instruction
ex_mem_read  input  1  ID/EX stage holds a load (lw)
ex_rt  input  5  destination rt of the instruction in EX
mem_branch  input  1  EX/MEM stage holds a beq
mem_zero  input  1  ALU zero flag latched in EX/MEM
id_instr  output  32  IF/ID register: instruction in decode
id_pc_plus4  output  32  IF/ID register: PC+4 in decode
pc_write  output  1  1 = PC register may update
pc_src  output  1  1 = PC loads branch target, 0 = PC+4
id_ex_bubble  output  1  1 = zero control fields entering ID/EX
flush_ex  output  1  1 = zero control fields in ID/EX and EX/MEM on next edge
state_o  output  2  current FSM state (debug)
stall_cnt  output  CNT_W  load-use stall cycles taken
flush_cnt  output  CNT_W  taken-branch flushes

Behaviour:
- Reset (reset=1 at clk edge): id_instr=NOP, id_pc_plus4=0, state=RUN, both counters=0. Combinational outputs then evaluate from RUN with NOP in ID, giving pc_write=1, pc_src=0, id_ex_bubble=0, flush_ex=0. Reset overrides every other input in the same cycle.
- Decode fields of id_instr: op=[31:26], rs=[25:21], rt=[20:16].
- uses_rs = op in {000000 R-type, 100011 lw, 101011 sw, 000100 beq}.
- uses_rt = op in {000000, 101011, 000100}.
- Other opcodes use neither field.
- hazard = ex_mem_read & (ex_rt != 0) & ((uses_rs & rs==ex_rt) | (uses_rt & rt==ex_rt)).
- taken = mem_branch & mem_zero.
- FSM states, encoded on state_o: RUN=0, STALL=1, FLUSH=2.
- Priority within a cycle: taken > hazard > normal advance.
- RUN, taken: pc_src=1, pc_write=1, flush_ex=1, id_ex_bubble=1. IF/ID loads NOP and 0 next edge. flush_cnt+1. Next state FLUSH.
- RUN, hazard & !taken: pc_write=0, id_ex_bubble=1. IF/ID holds its value. stall_cnt+1. Next state STALL.
- RUN, otherwise: pc_write=1, pc_src=0. IF/ID loads if_instr and if_pc_plus4. Stay in RUN.
- STALL: a single bubble cycle. Hazard is re-evaluated, because a second lw may now sit in EX after its own bubble, so back-to-back load-use must stall again. taken still has priority. Transitions follow the same rules as RUN, with the target RUN when no event occurs.
- FLUSH: IF/ID holds NOP. Hazard detection is masked. pc_write=1, pc_src=0, IF/ID loads the fetch, next state RUN. If taken is asserted again in FLUSH, it is handled as in RUN and the block stays in FLUSH.
- Counters saturate at all-ones and never wrap.
- Latency: IF/ID output valid one cycle after fetch. A stall inserts exactly one bubble per load-use. A branch flush squashes exactly the instructions in IF/ID, ID/EX and EX/MEM.
- Register $0 is never a hazard source (ex_rt==0 is excluded).

Decomposition:
- Shared package pipe_pkg holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), the state encoding (ST_RUN, ST_STALL, ST_FLUSH) and NOP.
- One natural sub-module, hazard_detect: purely combinational. Inputs are id_instr, ex_mem_read and ex_rt; output is hazard.
- The FSM, IF/ID register and counters live in the top.

Test Plan:
- Reset mid-stall: assert reset while state=STALL -> next cycle state_o=0, id_instr=0, stall_cnt=0, pc_write=1.
- Load-use: id_instr=add $3,$2,$4 (0x00441820), ex_mem_read=1, ex_rt=2 -> pc_write=0, id_ex_bubble=1 for one cycle, id_instr held, stall_cnt=1, then RUN with pc_write=1.
- No false stall: id_instr=add $3,$2,$4, ex_rt=0, ex_mem_read=1 -> no stall. Separately, id_instr=lw $5,0($6) (0x8CC50000) with ex_rt=5 -> no stall, because lw does not use rt.
- Taken branch: mem_branch=1, mem_zero=1 -> pc_src=1, flush_ex=1, next id_instr=0, flush_cnt=1, state_o=2, then RUN.
- Simultaneous: hazard condition true and taken=1 in the same cycle -> flush path only, stall_cnt unchanged, pc_write=1.
- Saturation: with CNT_W=2, force 5 load-use stalls -> stall_cnt stops at 3.
